// File: rtl/imem_loader.sv
// Byte-stream loader for the 32-entry instruction store: assembles big-endian words
// from a valid/ready byte stream and holds the CPU until a full image is written.
//
// state | meaning
// IDLE  | no load yet since reset; CPU held
// LOAD  | accepting bytes and writing words; CPU held
// DONE  | image complete; CPU released, fetch reads the store
module imem_loader #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W:0]   word_count,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   words_loaded,
    output logic              cpu_hold
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   ptr;
    logic [ADDR_W:0]     count_q;
    logic [1:0]          byte_idx;
    logic [DATA_W-9:0]   partial;

    logic [DATA_W-1:0]   mem [DEPTH];

    logic                count_ok;
    logic                accept;
    logic                word_wr;
    logic                last_word;

    assign count_ok  = (word_count != '0) && (word_count <= DEPTH_CNT);
    assign accept    = (state == LOAD) && byte_valid && byte_ready;
    assign word_wr   = accept && (byte_idx == 2'd3);
    assign last_word = (({1'b0, ptr} + (ADDR_W + 1)'(1)) == count_q);

    // The store itself has no reset so a program image survives rst_n.
    always_ff @(posedge clk) begin
        if (word_wr) begin
            mem[ptr] <= {partial, byte_data};
        end
    end

    assign rd_data = mem[rd_addr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            byte_ready   <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            cpu_hold     <= 1'b1;
            words_loaded <= '0;
            ptr          <= '0;
            count_q      <= '0;
            byte_idx     <= '0;
            partial      <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        if (count_ok) begin
                            state        <= LOAD;
                            count_q      <= word_count;
                            ptr          <= '0;
                            byte_idx     <= '0;
                            words_loaded <= '0;
                            err          <= 1'b0;
                            byte_ready   <= 1'b1;
                            busy         <= 1'b1;
                            done         <= 1'b0;
                            cpu_hold     <= 1'b1;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end

                LOAD: begin
                    if (accept) begin
                        case (byte_idx)
                            2'd0: partial[DATA_W-9 -: 8] <= byte_data;
                            2'd1: partial[DATA_W-17 -: 8] <= byte_data;
                            2'd2: partial[7:0] <= byte_data;
                            default: ;
                        endcase

                        if (byte_idx == 2'd3) begin
                            byte_idx     <= '0;
                            words_loaded <= words_loaded + 1'b1;
                            // Final word: park the pointer instead of letting it wrap to 0.
                            if (last_word) begin
                                state      <= DONE;
                                byte_ready <= 1'b0;
                                busy       <= 1'b0;
                                done       <= 1'b1;
                                cpu_hold   <= 1'b0;
                            end else begin
                                ptr <= ptr + 1'b1;
                            end
                        end else begin
                            byte_idx <= byte_idx + 2'd1;
                        end
                    end
                end

                default: begin
                    state      <= IDLE;
                    byte_ready <= 1'b0;
                    busy       <= 1'b0;
                    done       <= 1'b0;
                    cpu_hold   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Writer side of the CPU's 32-entry instruction memory. It accepts a byte stream through a valid/ready handshake and assembles big-endian 32-bit words. Each completed word is written into an internal 32x32 instruction store. The same store is presented to the PC/IF stage as a combinational read port, and the CPU is held via cpu_hold until a complete program image has been loaded.

Parameters:
ADDR_W, 5, instruction word address width; DEPTH = 2**ADDR_W words (32 by default)
DATA_W, 32, instruction word width; fixed at 32, 4 bytes per word

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  single-cycle load request, sampled in IDLE and DONE only
word_count  input  ADDR_W+1  number of words to load, valid range 1..DEPTH, latched on accepted start
byte_valid  input  1  byte_data is valid this cycle
byte_data  input  8  program image byte, most significant byte of each word first
byte_ready  output  1  loader accepts a byte this cycle
rd_addr  input  ADDR_W  fetch word address from PC/IF
rd_data  output  DATA_W  combinational read of mem[rd_addr]
busy  output  1  high in LOAD
done  output  1  high in DONE
err  output  1  sticky flag for a rejected start
words_loaded  output  ADDR_W+1  count of words written in the current or last load
cpu_hold  output  1  high holds the CPU; low only in DONE

Behaviour:
- State machine: IDLE, LOAD, DONE; state is registered and all control outputs are decoded from state (Moore).
- Reset (async, rst_n=0):
  - State returns to IDLE immediately.
  - byte_ready=0, busy=0, done=0, err=0, cpu_hold=1, words_loaded=0.
  - Byte index and partial word are cleared.
  - Memory array is not reset; its contents are retained across reset.
- IDLE:
  - On start=1 with word_count in 1..DEPTH: latch the count, clear the write pointer, byte index, words_loaded and err; next state is LOAD.
  - On start=1 with word_count=0 or word_count>DEPTH: set err=1 and remain in IDLE; no write occurs.
- LOAD:
  - byte_ready=1, busy=1, cpu_hold=1.
  - A byte is accepted on any rising edge with byte_valid && byte_ready.
  - Byte index 0..3 places the byte into bits [31:24], [23:16], [15:8], [7:0] respectively.
  - On acceptance of byte index 3, on that same edge: mem[ptr] <= {held bytes 0..2, current byte}; ptr increments; words_loaded increments; byte index returns to 0.
  - If that write is the final word (ptr+1 == latched count), next state is DONE and byte_ready is 0 from the following cycle.
  - byte_valid=0 cycles stall the load with no state change and no timeout.
  - start is ignored while in LOAD.
- DONE:
  - done=1, cpu_hold=0, byte_ready=0, busy=0.
  - start=1 with a valid count begins a new load, identical to the IDLE rules; done=0 and cpu_hold=1 take effect from the next cycle.
  - start=1 with an invalid count sets err=1 and stays in DONE.
- Read port:
  - rd_data = mem[rd_addr] with no latency, in all states.
  - A word written on edge N is visible on rd_data after edge N.
  - Reading a location never written returns undefined data.
- Pointer/count width and boundaries:
  - ptr is ADDR_W bits; words_loaded is ADDR_W+1 bits so a full load of DEPTH words reads back as 32.
  - A full load writes addresses 0..DEPTH-1 and terminates at DEPTH-1; ptr never wraps to overwrite address 0.
  - The latched count is compared against the ADDR_W+1-bit value ptr+1.
- byte_valid outside LOAD is ignored, since byte_ready=0.
- Reset mid-word: the partial word is discarded and previously written words remain in memory. words_loaded reads 0 after the reset.

Test Plan:
- Reset with rst_n=0 asserted mid-cycle -> byte_ready=0, busy=0, done=0, err=0, cpu_hold=1, words_loaded=0, all asynchronously.
- start, word_count=2; bytes 20,08,00,05,00,00,00,00 sent back-to-back -> mem[0]=32'h20080005, mem[1]=32'h00000000. done=1 and cpu_hold=0 on the cycle after the 8th byte edge, words_loaded=2, rd_addr=0 reads 32'h20080005.
- Same load as above with byte_valid toggling 1,0,0,1 -> identical memory contents; byte_ready stays 1 throughout LOAD; completion is delayed only by the stall cycles.
- start with word_count=0, then with word_count=33 -> err=1, state stays IDLE, byte_ready=0, memory unchanged; a subsequent valid start clears err.
- word_count=32 with word k = 32'hA5A50000+k -> all 32 addresses written and done=1, words_loaded=32; rd_addr=31 reads 32'hA5A5001F, rd_addr=0 still reads 32'hA5A50000.
- word_count=4: after 3 full words and 2 bytes of word 3, assert rst_n=0 -> immediate IDLE, words 0..2 readable, mem[3] unchanged. A restart with word_count=1 then overwrites only mem[0].
